serial_addsub16: RTL

SERIAL_ADDSUB16 -- requirements
Module: serial_addsub16

---
 rtl/serial_addsub16_pkg.sv | 19 +
 rtl/serial_addsub16_nibble_adder.sv | 12 +
 rtl/serial_addsub16.sv | 139 +++++++++++++
 3 files changed

// File: rtl/serial_addsub16_pkg.sv
// Shared types for serial_addsub16: FSM state encoding, op codes and the
// operand-B slice conditioning helper used by the nibble datapath.
package serial_addsub16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Subtraction adds the one's complement of B; the +1 enters as the initial carry.
  function automatic logic [3:0] b_slice_eff(input logic op, input logic [3:0] b);
    return (op == OP_SUB) ? ~b : b;
  endfunction

endpackage

// File: rtl/serial_addsub16_nibble_adder.sv
// 4-bit slice adder, time-shared across all nibbles of serial_addsub16.
module nibble_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};

endmodule

// File: rtl/serial_addsub16.sv
// Nibble-serial add/subtract with valid/ready handshakes on both sides.
// Optional saturation of overflowed results: define SERIAL_ADDSUB_SAT_EN.
module serial_addsub16
  import serial_addsub16_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 c_out,
  output logic                 ovf,
  output logic                 zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);
`ifdef SERIAL_ADDSUB_SAT_EN
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};
`endif

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic            r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_result;
  logic            r_c_out;
  logic            r_ovf;
  logic            r_zero;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_sum;
  logic            w_cout;
  logic [W-1:0]    w_res_raw;
  logic [W-1:0]    w_res_fin;
  logic            w_ovf;
  logic            w_zero;

  // Select the current nibble of each latched operand.
  always_comb begin
    w_a_nib = r_a[{r_cnt, 2'b00} +: 4];
    w_b_nib = b_slice_eff(r_op, r_b[{r_cnt, 2'b00} +: 4]);
  end

  nibble_adder u_nibble_adder (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Merge the new slice and derive flags; only meaningful on the last nibble.
  always_comb begin
    w_res_raw = r_result;
    w_res_raw[{r_cnt, 2'b00} +: 4] = w_sum;
    w_ovf = (w_a_nib[3] == w_b_nib[3]) && (w_sum[3] != w_a_nib[3]);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (w_ovf) begin
      w_res_fin = w_a_nib[3] ? SAT_NEG : SAT_POS;
    end else begin
      w_res_fin = w_res_raw;
    end
`else
    w_res_fin = w_res_raw;
`endif
    w_zero = (w_res_fin == {W{1'b0}});
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= {CW{1'b0}};
      r_carry  <= 1'b0;
      r_op     <= OP_ADD;
      r_a      <= {W{1'b0}};
      r_b      <= {W{1'b0}};
      r_result <= {W{1'b0}};
      r_c_out  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cnt   <= {CW{1'b0}};
            r_carry <= op;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_carry <= w_cout;
          if (r_cnt == LAST_NIB) begin
            r_result <= w_res_fin;
            r_c_out  <= w_cout;
            r_ovf    <= w_ovf;
            r_zero   <= w_zero;
            r_cnt    <= {CW{1'b0}};
            r_state  <= DONE;
          end else begin
            r_result <= w_res_raw;
            r_cnt    <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // in_ready is masked by rst_n so it reads 0 for the whole reset pulse.
  assign in_ready  = rst_n & (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
